// File: rtl/microwave_cook_timer.sv
// Microwave cook timer: four BCD digits mm:ss, keypad entry, countdown while mag_on.
// Optional "+30 s" key enabled by defining MW_TIMER_ADD30_EN.
module microwave_cook_timer #(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       clearn,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       add30,
    input  logic       mag_on,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       timer_done,
    output logic       running
);

    localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {IDLE, SET, RUN, DONE} state_t;

    state_t         state, state_nxt;
    logic [15:0]    time_q, time_nxt;
    logic [PW-1:0]  presc, presc_nxt, presc_inc;
    logic           done_nxt;
    logic           key_ok, add_ok, tick, time_zero;
    logic [15:0]    key_time;

    // BCD countdown by one second; sec_tens 6..9 simply decrements.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] mt, mo, st, so;
        {mt, mo, st, so} = t;
        if (so != 4'd0) so = so - 4'd1;
        else begin
            so = 4'd9;
            if (st != 4'd0) st = st - 4'd1;
            else begin
                st = 4'd5;
                if (mo != 4'd0) mo = mo - 4'd1;
                else begin
                    mo = 4'd9;
                    mt = mt - 4'd1;
                end
            end
        end
        return {mt, mo, st, so};
    endfunction

`ifdef MW_TIMER_ADD30_EN
    // +30 s with minute carry, saturating at 99:59.
    function automatic logic [15:0] bcd_add30(input logic [15:0] t);
        logic [3:0] mt, mo, st, so;
        logic [4:0] st_sum;
        {mt, mo, st, so} = t;
        st_sum = {1'b0, st} + 5'd3;
        if (st_sum >= 5'd6) begin
            st_sum = st_sum - 5'd6;
            st     = st_sum[3:0];
            if (mt == 4'd9 && mo == 4'd9) return 16'h9959;
            if (mo == 4'd9) begin
                mo = 4'd0;
                mt = mt + 4'd1;
            end else begin
                mo = mo + 4'd1;
            end
        end else begin
            st = st_sum[3:0];
        end
        return {mt, mo, st, so};
    endfunction

    assign add_ok = add30;
`else
    logic unused_add30;
    assign unused_add30 = add30;
    assign add_ok       = 1'b0;
`endif

    assign key_ok    = key_valid && (key_digit <= 4'd9) && !mag_on;
    assign key_time  = {time_q[11:0], key_digit};
    assign time_zero = (time_q == 16'h0000);
    assign tick      = (state == RUN) && mag_on && (presc == PRESC_MAX);
    assign presc_inc = (presc == PRESC_MAX) ? '0 : presc + 1'b1;

    assign {min_tens, min_ones, sec_tens, sec_ones} = time_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            running <= 1'b0;
        end else begin
            state   <= state_nxt;
            running <= (state_nxt == RUN);
        end
    end

    always_comb begin
        state_nxt = state;
        if (!clearn) begin
            state_nxt = IDLE;
        end else if (key_ok) begin
            state_nxt = (key_time != 16'h0000) ? SET : IDLE;
        end else if (add_ok) begin
            case (state)
                IDLE, DONE: state_nxt = SET;
                RUN:        state_nxt = mag_on ? RUN : SET;
                default:    state_nxt = state;
            endcase
        end else begin
            case (state)
                IDLE, SET: if (mag_on && !time_zero) state_nxt = RUN;
                RUN: begin
                    if (!mag_on) state_nxt = SET;
                    else if (tick && time_q == 16'h0001) state_nxt = DONE;
                end
                default: state_nxt = state;
            endcase
        end
    end

    // Datapath next values; the add path drops a coincident tick.
    always_comb begin
        time_nxt  = time_q;
        presc_nxt = presc;
        done_nxt  = timer_done;
        if (!clearn) begin
            time_nxt  = 16'h0000;
            presc_nxt = '0;
            done_nxt  = 1'b0;
        end else if (key_ok) begin
            time_nxt  = key_time;
            presc_nxt = '0;
            done_nxt  = 1'b0;
        end else if (add_ok) begin
            done_nxt = 1'b0;
`ifdef MW_TIMER_ADD30_EN
            if (state == IDLE || state == DONE) time_nxt = 16'h0030;
            else time_nxt = bcd_add30(time_q);
`endif
            if (state == RUN && mag_on) presc_nxt = presc_inc;
        end else begin
            case (state)
                IDLE: done_nxt = mag_on;
                RUN: begin
                    if (mag_on) begin
                        presc_nxt = presc_inc;
                        if (tick) begin
                            time_nxt = bcd_dec(time_q);
                            if (time_q == 16'h0001) done_nxt = 1'b1;
                        end
                    end
                end
                DONE:    done_nxt = 1'b1;
                default: done_nxt = timer_done;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            time_q     <= 16'h0000;
            presc      <= '0;
            timer_done <= 1'b0;
        end else begin
            time_q     <= time_nxt;
            presc      <= presc_nxt;
            timer_done <= done_nxt;
        end
    end

endmodule
